// File: rtl/uo_change_logger.sv
// Change logger for a microtile uo_out bus: synchronizes the bus, detects value
// changes and queues {timestamp, value} entries in a small FIFO. Optional macro
// UO_LOG_TIMESTAMP_EN builds the 8-bit timestamp counter and storage.
module uo_change_logger #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ena,
  input  logic [7:0]               uo_in,
  output logic [15:0]              rd_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     overflow_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
`ifdef UO_LOG_TIMESTAMP_EN
  localparam int EW = 16;
`else
  localparam int EW = 8;
`endif

  logic [7:0]    sync1, sync2, prev;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] count;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;

  logic change, push_req, full, pop, wr_en, drop;

  // NOTE: non-blocking assignments make the sync chain shift one stage per edge;
  // blocking would collapse sync1/sync2/prev into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= uo_in;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

`ifdef UO_LOG_TIMESTAMP_EN
  logic [7:0] ts, ts_next;

  assign ts_next = ts + 8'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ts <= '0;
    else        ts <= ts_next;
  end

  // The stored stamp is the counter value the write edge produces.
  assign wr_entry = {ts_next, sync2};
  assign rd_data  = rd_valid ? head : 16'h0000;
`else
  assign wr_entry = sync2;
  assign rd_data  = rd_valid ? {8'h00, head} : 16'h0000;
`endif

  assign change   = (sync2 != prev);
  assign push_req = change && ena;
  assign rd_valid = (count != '0);
  assign full     = (count == LW'(DEPTH));
  assign pop      = rd_valid && rd_ready;
  assign wr_en    = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;
  assign level    = count;
  assign head     = mem[rd_ptr];

  // NOTE: storage has no reset; empty slots are never visible because rd_data
  // is gated by rd_valid, so clearing the array would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // A drop on the same edge as a clear leaves the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            overflow <= 1'b0;
    else if (drop)         overflow <= 1'b1;
    else if (overflow_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_uo_change_logger.sv
// Directed bench for uo_change_logger: a scoreboard queue holds entries expected
// to be logged; entries are compared as they are popped from the FIFO.
module tb_uo_change_logger;

  localparam int DEPTH = 4;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ena = 1'b1;
  logic [7:0]    uo_in = 8'h00;
  logic [15:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [LW-1:0] level;
  logic          overflow;
  logic          overflow_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [15:0] sb [$];

  uo_change_logger #(.DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ena          (ena),
    .uo_in        (uo_in),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .rd_ready     (rd_ready),
    .level        (level),
    .overflow     (overflow),
    .overflow_clr (overflow_clr)
  );

  always #5 clk = ~clk;

  // Edge count since reset release; edge 1 after release is count 1.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  function automatic logic [15:0] exp_entry(input logic [7:0] t, input logic [7:0] v);
`ifdef UO_LOG_TIMESTAMP_EN
    return {t, v};
`else
    return {8'h00, v};
`endif
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive a new bus value just after a falling edge; the write lands on the
  // third rising edge from here, so its stamp is the current count plus 3.
  task automatic change_to(input logic [7:0] v, input bit expect_write);
    uo_in = v;
    if (expect_write) sb.push_back(exp_entry(8'(cyc + 3), v));
  endtask

  task automatic pop_check(input string tag);
    logic [15:0] e;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=scoreboard_empty expected=entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_valid"}, 16'(rd_valid), 16'h1);
      check({tag, "_data"}, rd_data, e);
      rd_ready = 1'b1;
      tick(1);
      rd_ready = 1'b0;
    end
  endtask

  initial begin
    // Reset state
    #2;
    check("rst_valid", 16'(rd_valid), 16'h0);
    check("rst_level", 16'(level), 16'h0);
    check("rst_ovf", 16'(overflow), 16'h0);
    check("rst_data", rd_data, 16'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // First change: driven before edge 10, written on edge 12
    tick(9);
    change_to(8'h5A, 1'b1);
    check("first_ts_model", sb[0], exp_entry(8'd12, 8'h5A));
    tick(2);
    check("lat_not_yet", 16'(rd_valid), 16'h0);
    tick(1);
    check("lat_level", 16'(level), 16'h1);
    pop_check("first");
    check("empty_level", 16'(level), 16'h0);
    check("empty_data", rd_data, 16'h0);

    // Fill to full, fifth change dropped
    for (int i = 0; i < 5; i++) begin
      change_to(8'(8'h11 * (i + 1)), i < 4);
      if (i == 4) check("full_no_ovf_yet", 16'(overflow), 16'h0);
      tick(4);
    end
    check("full_level", 16'(level), 16'(DEPTH));
    check("full_ovf", 16'(overflow), 16'h1);
    check("full_head", rd_data, sb[0]);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("ovf_clr", 16'(overflow), 16'h0);
    check("ovf_clr_level", 16'(level), 16'(DEPTH));

    // Full with simultaneous pop and write
    change_to(8'h66, 1'b1);
    tick(2);
    check("sim_head_old", rd_data, sb.pop_front());
    rd_ready = 1'b1;
    tick(1);
    rd_ready = 1'b0;
    check("sim_level", 16'(level), 16'(DEPTH));
    check("sim_ovf", 16'(overflow), 16'h0);
    check("sim_head_new", rd_data, sb[0]);

    // Drop and clear on the same edge: set wins
    change_to(8'h77, 1'b0);
    tick(2);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("setwins_ovf", 16'(overflow), 16'h1);
    check("setwins_level", 16'(level), 16'(DEPTH));
    check("setwins_head", rd_data, sb[0]);
    overflow_clr = 1'b1;
    tick(1);
    overflow_clr = 1'b0;
    check("setwins_clr", 16'(overflow), 16'h0);

    // Drain, including the newest entry, then ready on empty is ignored
    for (int i = 0; i < DEPTH; i++) pop_check("drain");
    check("drain_level", 16'(level), 16'h0);
    check("drain_data", rd_data, 16'h0);
    rd_ready = 1'b1;
    tick(2);
    rd_ready = 1'b0;
    check("ready_empty_level", 16'(level), 16'h0);

    // ena falls with entries queued; toggling while disabled logs nothing
    change_to(8'hA1, 1'b1);
    tick(4);
    change_to(8'hA2, 1'b1);
    tick(4);
    ena = 1'b0;
    for (int i = 0; i < 10; i++) begin
      uo_in = (i % 2 == 0) ? 8'h01 : 8'h02;
      tick(1);
    end
    tick(3);
    ena = 1'b1;
    tick(5);
    check("ena_off_level", 16'(level), 16'h2);
    pop_check("ena_off_a");
    pop_check("ena_off_b");
    check("ena_off_empty", 16'(level), 16'h0);

    // Mid-cycle reset discards queued entries; nonzero bus logs once after
    change_to(8'hB1, 1'b1);
    tick(4);
    change_to(8'hB2, 1'b1);
    tick(4);
    check("pre_rst_level", 16'(level), 16'h2);
    uo_in = 8'h3C;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", 16'(rd_valid), 16'h0);
    check("async_rst_level", 16'(level), 16'h0);
    check("async_rst_ovf", 16'(overflow), 16'h0);
    check("async_rst_data", rd_data, 16'h0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(exp_entry(8'(cyc + 3), 8'h3C));
    tick(2);
    check("post_rst_lat", 16'(rd_valid), 16'h0);
    tick(1);
    check("post_rst_level", 16'(level), 16'h1);
    pop_check("post_rst");

    // Quiet bus for 20 cycles logs nothing
    tick(20);
    check("idle_valid", 16'(rd_valid), 16'h0);
    check("idle_level", 16'(level), 16'h0);
    check("idle_ovf", 16'(overflow), 16'h0);

    // Timestamp wrap: write lands on edge 256 (stamp 0), then one after 300
    for (int i = 0; i < 400 && cyc != 253; i++) tick(1);
    change_to(8'hC3, 1'b1);
    tick(4);
    pop_check("wrap0");
    for (int i = 0; i < 400 && cyc < 300; i++) tick(1);
    change_to(8'hD4, 1'b1);
    tick(4);
    pop_check("wrap_late");
    check("final_level", 16'(level), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uo_change_logger.md
UO_CHANGE_LOGGER -- requirements
Module: uo_change_logger

Interface
REQ-001 SHALL have parameter DEPTH, default 4, FIFO entry count; power of two, 2..16.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port ena  input  1  logging enable; 0 blocks FIFO writes.
REQ-005 SHALL have port uo_in  input  8  microtile uo_out bus, asynchronous to clk.
REQ-006 SHALL have port rd_data  output  16  head entry: [15:8] timestamp, [7:0] value.
REQ-007 SHALL have port rd_valid  output  1  FIFO non-empty.
REQ-008 SHALL have port rd_ready  input  1  consumer accepts head when rd_valid=1.
REQ-009 SHALL have port level  output  $clog2(DEPTH)+1  current entry count.
REQ-010 SHALL have port overflow  output  1  sticky: a change was dropped.
REQ-011 SHALL have port overflow_clr  input  1  synchronous clear of overflow.

Function
REQ-012 SHALL pass uo_in through a two-flop synchronizer (sync1, sync2) before any use.
REQ-013 SHALL hold prev, updated to sync2 every cycle regardless of ena.
REQ-014 SHALL raise change when sync2 != prev; write {ts, sync2} on that edge iff ena=1.
REQ-015 Latency: uo_in stable before edge k -> sync2 at k+1 -> write at k+2 -> rd_valid=1 after edge k+2.
REQ-016 SHALL keep ts as an 8-bit free-running counter, +1 per cycle, wrapping 255->0; stored ts is the counter value at the write edge.
REQ-017 Pop on rising edge when rd_valid=1 and rd_ready=1; rd_ready ignored when rd_valid=0.
REQ-018 rd_data SHALL show the head entry combinationally from storage; undefined content not allowed (reads 0 when empty).
REQ-019 Full and no pop: write dropped, overflow set at same edge, FIFO contents unchanged.
REQ-020 Full with simultaneous pop and write: both performed, level stays DEPTH, overflow unchanged.
REQ-021 Empty with write: no bypass; rd_valid rises the following cycle.
REQ-022 overflow_clr and a new drop on same edge: overflow SHALL end at 1 (set wins).
REQ-023 Read/write pointers SHALL wrap modulo DEPTH; level = writes minus pops, never exceeds DEPTH.
REQ-024 ena falling mid-stream SHALL NOT discard stored entries; reads continue.

Reset
REQ-025 On rst_n=0, immediately: sync1, sync2, prev, ts, pointers cleared to 0; rd_valid=0, level=0, overflow=0, rd_data=0.
REQ-026 Reset asserted mid-operation SHALL discard all queued entries; no entry logged for reset itself.
REQ-027 After release, uo_in nonzero SHALL log one entry (prev resets to 0).

Configuration
REQ-028 Macro UO_LOG_TIMESTAMP_EN: defined -> ts counter built, rd_data[15:8] carries timestamp.
REQ-029 UO_LOG_TIMESTAMP_EN undefined -> no counter or timestamp storage; rd_data[15:8] tied 0; all other behaviour identical.

Verification
REQ-030 Reset release, uo_in=0x00, ena=1, 20 cycles -> rd_valid=0, level=0, overflow=0.
REQ-031 uo_in 0x00->0x5A before edge 10 after reset release, rd_ready=0 -> rd_valid=1 after edge 12, rd_data=0x0C5A (with macro; ts counted from edge 1 = 1, edge 12 = 12), 0x005A without.
REQ-032 DEPTH=4, rd_ready=0, five distinct changes spaced 4 cycles -> level=4, overflow=1, head value = first change; overflow_clr pulse -> overflow=0.
REQ-033 Full FIFO, rd_ready=1 on the same edge as a new change write -> level stays 4, oldest popped, newest present, overflow stays 0.
REQ-034 ena=0 while uo_in toggles 0x01/0x02 for 10 cycles, then ena=1 with uo_in stable -> no entries logged.
REQ-035 Two entries queued, rst_n pulsed low mid-cycle -> rd_valid, level, overflow drop to 0 asynchronously; ts wraps 255->0 checked in a 300-cycle run.
